// File: rtl/shift_add_datapath.sv
// Shift-add multiplier datapath stepped by external controller strobes; product = {A,Q}.
// Optional protocol checker enabled by defining SHIFT_ADD_DATAPATH_CHECK_EN.
module shift_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               Load_regs,
  input  logic               Add_regs,
  input  logic               Shift_regs,
  input  logic               Decre_P,
  input  logic               ready,
  output logic               pulso,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               err
);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [PW-1:0] P_INIT = PW'(WIDTH);

  logic [1:0]       state;
  logic             c;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [PW-1:0]    p;
  logic [WIDTH:0]   sum;
  logic             run;

  assign sum   = {1'b0, a} + {1'b0, m};
  assign run   = (state == RUN);
  assign pulso = q[0];
  assign zero  = (p == '0);
  assign busy  = run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      c       <= 1'b0;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      p       <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            a     <= '0;
            c     <= 1'b0;
            p     <= P_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          // add takes priority; a simultaneous shift is dropped
          if (Add_regs) begin
            {c, a} <= sum;
          end else if (Shift_regs) begin
            {c, a, q} <= {1'b0, c, a, q[WIDTH-1:1]};
          end
          if (Decre_P && (p != '0)) begin
            p <= p - 1'b1;
          end
          if (ready) begin
            state   <= DONE;
            done    <= 1'b1;
            product <= {a, q};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_ADD_DATAPATH_CHECK_EN
  logic [2:0] n_seq;
  logic       viol;
  logic       err_q;

  always_comb begin
    n_seq = {2'b00, Load_regs} + {2'b00, Shift_regs} + {2'b00, Decre_P} + {2'b00, ready};
    viol  = run && ((Add_regs && Shift_regs) || (n_seq > 3'd1) ||
                    (Decre_P && (p == '0)) || (ready && (p != '0)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (viol) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_add_datapath.sv
// Bench for shift_add_datapath: driver issues controller-style runs, monitor scores products on done.
module tb_shift_add_datapath;
  localparam int W = 8;
`ifdef SHIFT_ADD_DATAPATH_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           Load_regs = 1'b0;
  logic           Add_regs = 1'b0;
  logic           Shift_regs = 1'b0;
  logic           Decre_P = 1'b0;
  logic           ready = 1'b0;
  logic           pulso, zero, busy, done, err;
  logic [2*W-1:0] product;

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] sb[$];
  logic prev_done = 1'b0;

  shift_add_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .Load_regs(Load_regs), .Add_regs(Add_regs), .Shift_regs(Shift_regs),
    .Decre_P(Decre_P), .ready(ready),
    .pulso(pulso), .zero(zero), .busy(busy), .done(done),
    .product(product), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expected product
  initial begin
    logic [2*W-1:0] exp_p;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_p = sb.pop_front();
          check("product", {16'd0, product}, {16'd0, exp_p});
        end
      end
      prev_done = done;
    end
  end

  task automatic run_mult(input logic [W-1:0] mv, input logic [W-1:0] qv,
                          input logic [2*W-1:0] expv, input bit pulso_low,
                          input bit chk_c, input bit restart);
    @(negedge clk);
    start = 1'b1; multiplicand = mv; multiplier = qv;
    sb.push_back(expv);
    @(negedge clk);
    start = 1'b0; Load_regs = 1'b1;
    @(negedge clk);
    Load_regs = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (pulso_low) check("pulso_low", {31'd0, pulso}, 32'd0);
      if (i == W - 1) check("zero_before_last", {31'd0, zero}, 32'd0);
      Add_regs = pulso; Decre_P = 1'b1;
      if (restart && i == 2) begin
        start = 1'b1; multiplicand = 8'd3; multiplier = 8'd4;
      end
      @(negedge clk);
      Add_regs = 1'b0; Decre_P = 1'b0; start = 1'b0; Shift_regs = 1'b1;
      if (chk_c && i == 1) check("carry_after_add", {31'd0, dut.c}, 32'd1);
      @(negedge clk);
      Shift_regs = 1'b0;
    end
    check("zero_after_decr", {31'd0, zero}, 32'd1);
    check("busy_in_run", {31'd0, busy}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_pulso", {31'd0, pulso}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    run_mult(8'd13, 8'd11, 16'h008F, 1'b0, 1'b0, 1'b0);
    run_mult(8'd255, 8'd255, 16'hFE01, 1'b0, 1'b1, 1'b0);
    run_mult(8'd200, 8'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_mult(8'd7, 8'd9, 16'h003F, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("busy_after_runs", {31'd0, busy}, 32'd0);
    check("err_clean_runs", {31'd0, err}, 32'd0);
    check("product_held", {16'd0, product}, 32'h003F);

    // reset in the middle of an operation
    start = 1'b1; multiplicand = 8'd50; multiplier = 8'd61;
    @(negedge clk);
    start = 1'b0; Add_regs = 1'b1;
    @(negedge clk);
    Add_regs = 1'b0; Shift_regs = 1'b1;
    @(negedge clk);
    Shift_regs = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", {31'd0, done}, 32'd0);

    // add and shift together: add wins, checker flags it
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'd2;
    @(negedge clk);
    start = 1'b0; Add_regs = 1'b1; Shift_regs = 1'b1;
    @(negedge clk);
    Add_regs = 1'b0; Shift_regs = 1'b0;
    check("addshift_a", {24'd0, dut.a}, 32'd5);
    check("addshift_pulso", {31'd0, pulso}, 32'd0);
    check("addshift_err", {31'd0, err}, {31'd0, EXP_ERR});
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, {31'd0, EXP_ERR});
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("err_cleared", {31'd0, err}, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
